// File: rtl/scan_access_arbiter_if.sv
// rtl/scan_access_arbiter_if.sv - request/response and scan-controller bundle for scan_access_arbiter
interface scan_access_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int SEL_W   = 9,
  parameter int IO_W    = 8
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*SEL_W-1:0] req_select;
  logic [NUM_REQ*IO_W-1:0]  req_inputs;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ-1:0]       rsp_valid;
  logic [IO_W-1:0]          rsp_outputs;
  logic                     rsp_error;
  logic [SEL_W-1:0]         ctrl_active_select;
  logic [IO_W-1:0]          ctrl_inputs;
  logic [IO_W-1:0]          ctrl_outputs;
  logic                     ctrl_ready;

  modport slave (
    input  req_valid, req_select, req_inputs, ctrl_outputs, ctrl_ready,
    output req_ready, rsp_valid, rsp_outputs, rsp_error, ctrl_active_select, ctrl_inputs
  );

  modport master (
    output req_valid, req_select, req_inputs, ctrl_outputs, ctrl_ready,
    input  req_ready, rsp_valid, rsp_outputs, rsp_error, ctrl_active_select, ctrl_inputs
  );
endinterface

// File: rtl/scan_access_arbiter.sv
// rtl/scan_access_arbiter.sv - round-robin sharing of one scan controller among NUM_REQ requesters
// Optional macro SCAN_ARB_STATS_EN adds saturating stat_done/stat_timeout counters.
module scan_access_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int SEL_W          = 9,
  parameter int IO_W           = 8,
  parameter int NUM_DESIGNS    = 100,
  parameter int TIMEOUT_CYCLES = 4095
) (
  input  logic               clk,
  input  logic               reset,
  scan_access_arbiter_if.slave bus
`ifdef SCAN_ARB_STATS_EN
  ,
  output logic [15:0]        stat_done,
  output logic [15:0]        stat_timeout
`endif
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TIMER_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, FLUSH, CAPTURE, RESP} state_t;

  state_t             state;
  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   owner;
  logic [PTR_W-1:0]   winner;
  logic               any_valid;
  int                 idx;
  logic [SEL_W-1:0]   win_sel;
  logic [IO_W-1:0]    win_inputs;
  logic               win_legal;
  logic [CNT_W-1:0]   timer;
  logic [SEL_W-1:0]   sel_q;
  logic [IO_W-1:0]    inputs_q;
  logic [IO_W-1:0]    outputs_q;
  logic [NUM_REQ-1:0] ready;
  logic [NUM_REQ-1:0] rsp_valid_q;
  logic               rsp_error_q;
  logic               timed_out;

  // Search upward from the requester after the last grant, wrapping around.
  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    idx       = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!any_valid && bus.req_valid[idx]) begin
        any_valid = 1'b1;
        winner    = PTR_W'(idx);
      end
    end
  end

  assign win_sel    = bus.req_select[int'(winner)*SEL_W +: SEL_W];
  assign win_inputs = bus.req_inputs[int'(winner)*IO_W +: IO_W];
  assign win_legal  = int'(win_sel) < NUM_DESIGNS;

  always_comb begin
    ready = '0;
    if (state == IDLE && any_valid) ready = NUM_REQ'(1) << winner;
  end

  assign bus.req_ready          = ready;
  assign bus.rsp_valid          = rsp_valid_q;
  assign bus.rsp_outputs        = outputs_q;
  assign bus.rsp_error          = rsp_error_q;
  assign bus.ctrl_active_select = sel_q;
  assign bus.ctrl_inputs        = inputs_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      ptr         <= PTR_W'(NUM_REQ - 1);
      owner       <= '0;
      timer       <= '0;
      sel_q       <= '0;
      inputs_q    <= '0;
      outputs_q   <= '0;
      rsp_valid_q <= '0;
      rsp_error_q <= 1'b0;
      timed_out   <= 1'b0;
    end else begin
      rsp_valid_q <= '0;
      case (state)
        IDLE: begin
          if (any_valid) begin
            owner <= winner;
            ptr   <= winner;
            if (win_legal) begin
              sel_q    <= win_sel;
              inputs_q <= win_inputs;
              timer    <= '0;
              state    <= FLUSH;
            end else begin
              rsp_error_q <= 1'b1;
              rsp_valid_q <= NUM_REQ'(1) << winner;
              timed_out   <= 1'b0;
              state       <= RESP;
            end
          end
        end
        // The scan cycle in flight may have latched the previous select/inputs.
        FLUSH: begin
          if (bus.ctrl_ready) begin
            timer <= '0;
            state <= CAPTURE;
          end else if (timer == TIMER_LAST) begin
            outputs_q   <= '0;
            rsp_error_q <= 1'b1;
            rsp_valid_q <= NUM_REQ'(1) << owner;
            timed_out   <= 1'b1;
            state       <= RESP;
          end else begin
            timer <= timer + CNT_W'(1);
          end
        end
        CAPTURE: begin
          if (bus.ctrl_ready) begin
            outputs_q   <= bus.ctrl_outputs;
            rsp_error_q <= 1'b0;
            rsp_valid_q <= NUM_REQ'(1) << owner;
            timed_out   <= 1'b0;
            state       <= RESP;
          end else if (timer == TIMER_LAST) begin
            outputs_q   <= '0;
            rsp_error_q <= 1'b1;
            rsp_valid_q <= NUM_REQ'(1) << owner;
            timed_out   <= 1'b1;
            state       <= RESP;
          end else begin
            timer <= timer + CNT_W'(1);
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SCAN_ARB_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_done    <= '0;
      stat_timeout <= '0;
    end else if (state == RESP) begin
      if (stat_done != 16'hFFFF) stat_done <= stat_done + 16'd1;
      if (timed_out && stat_timeout != 16'hFFFF) stat_timeout <= stat_timeout + 16'd1;
    end
  end
`endif
endmodule

// File: doc/scan_access_arbiter.md
Name: scan_access_arbiter

Overview:
- Shares the single scan controller (active_select/inputs/outputs/ready interface) between NUM_REQ independent requesters.
- Each requester asks for one design transaction: drive inputs to a selected design and read back its outputs.
- Round-robin grant; sequences the controller so captured outputs always come from a full scan cycle run with the new select/inputs.
- Sits between the host-side request sources and the scan controller; the scan chain itself is untouched.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- SEL_W, 9, width of design select
- IO_W, 8, width of design inputs/outputs
- NUM_DESIGNS, 100, designs on chain; select >= NUM_DESIGNS is illegal
- TIMEOUT_CYCLES, 4095, max cycles waited for each ctrl_ready pulse

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  per-requester request, held until accepted
- req_select  in  NUM_REQ*SEL_W  packed selects, requester i at [i*SEL_W +: SEL_W]
- req_inputs  in  NUM_REQ*IO_W  packed inputs, requester i at [i*IO_W +: IO_W]
- req_ready  out  NUM_REQ  one-hot accept pulse (combinational, IDLE only)
- rsp_valid  out  NUM_REQ  one-hot one-cycle response pulse to the accepted requester
- rsp_outputs  out  IO_W  captured design outputs, held until next response
- rsp_error  out  1  qualifies rsp_valid: 1 = illegal select or timeout
- ctrl_active_select  out  SEL_W  to scan controller
- ctrl_inputs  out  IO_W  to scan controller
- ctrl_outputs  in  IO_W  from scan controller
- ctrl_ready  in  1  one-cycle pulse from scan controller at end of each scan cycle

Behaviour:
- Reset (reset=0, async): state IDLE; rr pointer = NUM_REQ-1 (requester 0 wins first); ctrl_active_select=0, ctrl_inputs=0, rsp_valid=0, rsp_outputs=0, rsp_error=0, timeout counter=0.
- States: IDLE, FLUSH, CAPTURE, RESP.
- IDLE: winner = first i with req_valid[i], searching from pointer+1 upward, wrapping. If any valid: req_ready[winner]=1 this cycle; on the edge latch owner=winner and pointer=winner.
  - Legal select: load ctrl_active_select/ctrl_inputs from the winner; go to FLUSH.
  - Illegal select: set err, leave ctrl_* unchanged; go to RESP.
- FLUSH: the current scan cycle may have started with old values; first ctrl_ready is discarded; go to CAPTURE.
- CAPTURE: on ctrl_ready, register ctrl_outputs into rsp_outputs, err=0; go to RESP.
- ctrl_ready pulses are counted only in FLUSH and CAPTURE; a pulse in the accept cycle is ignored.
- Timeout: counter clears on entry to FLUSH and CAPTURE and increments each cycle without ctrl_ready. On reaching TIMEOUT_CYCLES: err=1, rsp_outputs=0; go to RESP.
- RESP: one cycle; rsp_valid[owner]=1, rsp_error=err; then IDLE. The earliest next accept is the cycle after RESP.
- Latency: illegal select gives rsp_valid at accept+1. Legal request responds 1 cycle after the second counted ctrl_ready.
- ctrl_active_select/ctrl_inputs hold their values between transactions; the last design stays driven.
- Requester dropping req_valid after accept: no effect. New requests during a transaction wait; no queuing beyond req_valid hold.
- Reset mid-transaction: all state cleared immediately, no response issued, pointer back to NUM_REQ-1.

Optional Feature:
- Macro SCAN_ARB_STATS_EN.
- Defined: adds outputs stat_done[15:0] and stat_timeout[15:0], both saturating at 16'hFFFF and cleared by reset.
  - stat_done increments on every RESP.
  - stat_timeout increments on every RESP caused by a timeout.
- Not defined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Single legal request: req 0 valid, select=5, inputs=8'hA5; ctrl_ready pulses at accept+10 and accept+30, ctrl_outputs=8'h3C at the second pulse -> ctrl_active_select=5, ctrl_inputs=A5 from accept+1; rsp_valid=4'b0001, rsp_outputs=3C, rsp_error=0 at accept+31.
- Round-robin: all four valid continuously, fast ctrl_ready -> grant order 0,1,2,3,0. Then only reqs 1 and 3 valid after a grant to 1 -> next grant 3.
- Illegal select: req 2 select=100 -> rsp_valid=4'b0100, rsp_error=1 at accept+1; ctrl_active_select unchanged.
- Timeout (TIMEOUT_CYCLES=16): one ctrl_ready then silence -> rsp_error=1, rsp_outputs=0 exactly 16 cycles after CAPTURE entry.
- Reset mid-CAPTURE: assert reset asynchronously -> outputs zero immediately, no rsp_valid; afterwards requester 0 wins first.
- SCAN_ARB_STATS_EN: 3 good + 1 timeout transaction -> stat_done=4, stat_timeout=1.
